// File: rtl/pmodad1_sampler.sv
`default_nettype none
// ============================================================================
// Module   : pmodad1_sampler
// Function : PmodAD1 dual-channel 12-bit ADC conversion controller with an
//            internal sample timer, manual start and overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module pmodad1_sampler #(
    parameter int SAMPLE_DIV = 8000,
    parameter int SCLK_HALF  = 5,
    parameter int QUIET      = 10
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic        START,
    input  logic        CLR_OVR,
    input  logic        ADC_D0,
    input  logic        ADC_D1,
    output logic        ADC_CS_N,
    output logic        ADC_SCLK,
    output logic [11:0] DATA0,
    output logic [11:0] DATA1,
    output logic        VALID,
    output logic        BUSY,
    output logic        OVERRUN
);

    localparam int c_TW    = $clog2(SAMPLE_DIV);
    localparam int c_MAXPH = (SCLK_HALF > QUIET) ? SCLK_HALF : QUIET;
    localparam int c_PW    = (c_MAXPH > 1) ? $clog2(c_MAXPH) : 1;

    localparam logic [c_TW-1:0] c_T_LAST = c_TW'(SAMPLE_DIV - 1);
    localparam logic [c_TW-1:0] c_T_ONE  = c_TW'(1);
    localparam logic [c_PW-1:0] c_H_LAST = c_PW'(SCLK_HALF - 1);
    localparam logic [c_PW-1:0] c_Q_LAST = c_PW'(QUIET - 1);
    localparam logic [c_PW-1:0] c_P_ONE  = c_PW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_QUIET = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_TW-1:0] r_timer;
    logic [c_PW-1:0] r_phase;
    logic [c_PW-1:0] w_phase_nxt;
    logic [3:0]      r_bit;
    logic [3:0]      w_bit_nxt;
    logic            r_low;
    logic            w_low_nxt;
    logic            w_shift_en;
    logic [11:0]     r_sh0;
    logic [11:0]     r_sh1;
    logic            r_cs_n;
    logic            r_sclk;
    logic            r_busy;
    logic            r_valid;
    logic            r_ovr;
    logic [11:0]     r_data0;
    logic [11:0]     r_data1;
    logic            w_tick;
    logic            w_trig;

    assign w_tick = EN && (r_timer == c_T_LAST);
    assign w_trig = w_tick || START;

    always_ff @(posedge CLK) begin
        if (!RST_N || !EN || (r_timer == c_T_LAST)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_T_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_phase <= '0;
            r_bit   <= '0;
            r_low   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_low   <= w_low_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_low_nxt   = r_low;
        w_shift_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_state_nxt = S_SETUP;
                    w_phase_nxt = '0;
                end
            end
            S_SETUP: begin
                if (r_phase == c_H_LAST) begin
                    w_state_nxt = S_SHIFT;
                    w_phase_nxt = '0;
                    w_bit_nxt   = '0;
                    w_low_nxt   = 1'b1;
                end else begin
                    w_phase_nxt = r_phase + c_P_ONE;
                end
            end
            S_SHIFT: begin
                if (r_phase == c_H_LAST) begin
                    w_phase_nxt = '0;
                    if (r_low) begin
                        // last cycle of the low phase: data is stable here
                        w_shift_en = 1'b1;
                        w_low_nxt  = 1'b0;
                    end else if (r_bit == 4'd15) begin
                        w_state_nxt = S_QUIET;
                    end else begin
                        w_bit_nxt = r_bit + 4'd1;
                        w_low_nxt = 1'b1;
                    end
                end else begin
                    w_phase_nxt = r_phase + c_P_ONE;
                end
            end
            S_QUIET: begin
                if (r_phase == c_Q_LAST) begin
                    w_state_nxt = S_DONE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + c_P_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so pins change in
    // the first cycle of each state. Only the 12 data bits are kept: the
    // four leading zeros shift out the top and are never inspected.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b1;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_sh0   <= '0;
            r_sh1   <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_cs_n  <= !((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT));
            r_sclk  <= !((w_state_nxt == S_SHIFT) && w_low_nxt);
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= (w_state_nxt == S_DONE);
            if (w_trig && (r_state != S_IDLE)) begin
                r_ovr <= 1'b1;
            end else if (CLR_OVR) begin
                r_ovr <= 1'b0;
            end
            if (w_shift_en) begin
                r_sh0 <= {r_sh0[10:0], ADC_D0};
                r_sh1 <= {r_sh1[10:0], ADC_D1};
            end
            if (w_state_nxt == S_DONE) begin
                r_data0 <= r_sh0;
                r_data1 <= r_sh1;
            end
        end
    end

    assign ADC_CS_N = r_cs_n;
    assign ADC_SCLK = r_sclk;
    assign BUSY     = r_busy;
    assign VALID    = r_valid;
    assign OVERRUN  = r_ovr;
    assign DATA0    = r_data0;
    assign DATA1    = r_data1;

endmodule
`default_nettype wire

// File: tb/tb_pmodad1_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmodad1_sampler
// Function : Self-checking bench for pmodad1_sampler (small and default cfgs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmodad1_sampler;

    localparam int SD = 100;
    localparam int H  = 2;
    localparam int Q  = 3;
    localparam int L  = 33 * H + Q + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, start, clr_ovr, adc_d0, adc_d1;
    logic        cs_n, sclk, valid, busy, overrun;
    logic [11:0] data0, data1;

    logic        d_rst_n, d_en;
    logic        d_zero = 1'b0;
    logic        d_one  = 1'b1;
    logic        d_cs_n, d_sclk, d_valid, d_busy, d_ovr;
    logic [11:0] d_data0, d_data1;

    pmodad1_sampler #(.SAMPLE_DIV(SD), .SCLK_HALF(H), .QUIET(Q)) u_dut (
        .CLK(clk), .RST_N(rst_n), .EN(en), .START(start), .CLR_OVR(clr_ovr),
        .ADC_D0(adc_d0), .ADC_D1(adc_d1), .ADC_CS_N(cs_n), .ADC_SCLK(sclk),
        .DATA0(data0), .DATA1(data1), .VALID(valid), .BUSY(busy), .OVERRUN(overrun)
    );

    pmodad1_sampler u_def (
        .CLK(clk), .RST_N(d_rst_n), .EN(d_en), .START(d_zero), .CLR_OVR(d_zero),
        .ADC_D0(d_one), .ADC_D1(d_zero), .ADC_CS_N(d_cs_n), .ADC_SCLK(d_sclk),
        .DATA0(d_data0), .DATA1(d_data1), .VALID(d_valid), .BUSY(d_busy), .OVERRUN(d_ovr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic done_def = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference model: a frame is described only by its trigger cycle m_t0.
    int          cyc = 0;
    int          m_timer = 0;
    logic        m_have = 1'b0;
    int          m_t0 = 0;
    logic        m_ovr = 1'b0;
    logic [15:0] m_w0 = '0, m_w1 = '0;
    logic [15:0] n_w0 = '0, n_w1 = '0;
    logic [11:0] m_data0 = '0, m_data1 = '0;

    function automatic logic [28:0] expected();
        int   rel;
        logic e_cs, e_sclk, e_busy, e_valid;
        rel     = cyc - m_t0;
        e_cs    = !(m_have && rel >= 1 && rel <= 33 * H);
        e_sclk  = !(m_have && rel >= H + 1 && rel <= 33 * H && ((rel - H - 1) % (2 * H)) < H);
        e_busy  = m_have && rel >= 1 && rel <= L;
        e_valid = m_have && rel == L;
        return {e_cs, e_sclk, e_busy, e_valid, m_ovr, m_data0, m_data1};
    endfunction

    task automatic step(input logic rst_i, input logic st, input logic en_i, input logic clr_i);
        int   rel;
        int   k;
        logic trig, bsy;
        rel = cyc - m_t0;
        adc_d0 = 1'b0;
        adc_d1 = 1'b0;
        if (m_have && rel >= H + 1 && rel <= 33 * H) begin
            k = (rel - H - 1) / (2 * H);
            adc_d0 = m_w0[15 - k];
            adc_d1 = m_w1[15 - k];
        end
        rst_n = rst_i; start = st; en = en_i; clr_ovr = clr_i;
        if (!rst_i) begin
            m_have = 1'b0; m_ovr = 1'b0; m_timer = 0; m_data0 = '0; m_data1 = '0;
        end else begin
            trig = (en_i && m_timer == SD - 1) || st;
            bsy  = m_have && rel >= 1 && rel <= L;
            if (trig && bsy) begin
                m_ovr = 1'b1;
            end else begin
                if (clr_i) m_ovr = 1'b0;
                if (trig) begin
                    m_have = 1'b1; m_t0 = cyc; m_w0 = n_w0; m_w1 = n_w1;
                end
            end
            m_timer = en_i ? ((m_timer == SD - 1) ? 0 : m_timer + 1) : 0;
            if (m_have && (cyc + 1 - m_t0) == L) begin
                m_data0 = m_w0[11:0];
                m_data1 = m_w1[11:0];
            end
        end
        cyc++;
        @(negedge clk);
        check($sformatf("cycle %0d {cs,sclk,busy,valid,ovr,d0,d1}", cyc),
              {cs_n, sclk, busy, valid, overrun, data0, data1}, expected());
    endtask

    typedef struct {
        logic [15:0] w0;
        logic [15:0] w1;
        logic [11:0] e0;
        logic [11:0] e1;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   k, falls, badlen, run, vat, nv, last_v, min_gap;
        logic prev;
        logic e;

        tbl[0] = '{16'h0ABC, 16'h0123, 12'hABC, 12'h123};
        tbl[1] = '{16'h0FFF, 16'h0000, 12'hFFF, 12'h000};
        tbl[2] = '{16'h0000, 16'h0FFF, 12'h000, 12'hFFF};
        tbl[3] = '{16'hF5A5, 16'h0A5A, 12'h5A5, 12'hA5A};

        rst_n = 1'b0; en = 1'b1; start = 1'b0; clr_ovr = 1'b0; adc_d0 = 1'b0; adc_d1 = 1'b0;
        @(negedge clk);
        repeat (5) step(0, 0, 1, 0);

        // Timer held in reset: first tick 99 cycles after release.
        k = 0;
        do begin
            step(1, 0, 1, 0);
            k++;
        end while (cs_n && k < 200);
        check("first tick CS_N fall offset", k, 100);

        // EN dropped mid-frame: frame completes, nothing further starts.
        repeat (30) step(1, 0, 1, 0);
        nv = 0;
        for (int i = 0; i < 400; i++) begin
            step(1, 0, 0, 0);
            if (valid) nv++;
        end
        check("EN drop valid count", nv, 1);

        for (int t = 0; t < 4; t++) begin
            n_w0 = tbl[t].w0; n_w1 = tbl[t].w1;
            step(1, 1, 0, 0);
            falls = 0; badlen = 0; run = 0; vat = -1; prev = 1'b1;
            for (int i = 1; i <= L + 1; i++) begin
                if (i > 1) step(1, 0, 0, 0);
                if (prev && !sclk) falls++;
                if (!sclk) run++;
                if (!prev && sclk) begin
                    if (run != H) badlen++;
                    run = 0;
                end
                if (valid && vat < 0) vat = i;
                prev = sclk;
            end
            check($sformatf("frame %0d sclk falls", t), falls, 16);
            check($sformatf("frame %0d sclk low width", t), badlen, 0);
            check($sformatf("frame %0d valid latency", t), vat, L);
            check($sformatf("frame %0d DATA0", t), data0, tbl[t].e0);
            check($sformatf("frame %0d DATA1", t), data1, tbl[t].e1);
        end

        // Overrun, clear, and set-beats-clear.
        step(1, 1, 0, 0);
        repeat (19) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        nv = 0;
        for (int i = 0; i < L + 80; i++) begin
            step(1, 0, 0, 0);
            if (valid) nv++;
        end
        check("overrun single frame", nv, 1);
        check("overrun set", overrun, 1);
        step(1, 0, 0, 1);
        check("overrun cleared", overrun, 0);
        step(1, 1, 0, 0);
        repeat (10) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        check("overrun set beats clear", overrun, 1);
        repeat (L) step(1, 0, 0, 0);
        step(1, 0, 0, 1);

        // Trigger in DONE is an overrun; trigger in the cycle after DONE is not.
        step(1, 1, 0, 0);
        repeat (L - 1) step(1, 0, 0, 0);
        check("at DONE valid", valid, 1);
        step(1, 1, 0, 0);
        check("trigger in DONE overrun", overrun, 1);
        step(1, 0, 0, 1);
        step(1, 1, 0, 0);
        repeat (L) step(1, 0, 0, 0);
        check("after DONE idle", busy, 0);
        step(1, 1, 0, 0);
        check("after DONE accepted", {busy, overrun}, 2'b10);
        repeat (L + 2) step(1, 0, 0, 0);

        // Reset mid-SHIFT after bit 7.
        step(0, 0, 0, 0);
        n_w0 = 16'h0FFF; n_w1 = 16'h0FFF;
        step(1, 1, 0, 0);
        repeat (34) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("mid-shift reset pins", {cs_n, sclk, busy, valid}, 4'b1100);
        nv = 0;
        for (int i = 0; i < L + 20; i++) begin
            step(1, 0, 0, 0);
            if (valid) nv++;
        end
        check("mid-shift reset no valid", nv, 0);
        check("mid-shift reset DATA0", data0, 12'h000);

        // Periodic conversions.
        step(0, 0, 0, 0);
        nv = 0; last_v = -1; min_gap = 1000000;
        for (int i = 1; i <= 1071; i++) begin
            n_w0 = 16'($urandom); n_w1 = 16'($urandom);
            step(1, 0, 1, 0);
            if (valid) begin
                nv++;
                if (last_v >= 0 && (i - last_v) < min_gap) min_gap = i - last_v;
                last_v = i;
            end
        end
        check("periodic strobe count", nv, 10);
        check("periodic spacing", min_gap, SD);
        check("periodic no overrun", overrun, 0);

        // Random mix of EN, START, CLR_OVR and data.
        e = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            n_w0 = 16'($urandom); n_w1 = 16'($urandom);
            if ($urandom_range(0, 299) == 0) e = ~e;
            step(1, $urandom_range(0, 119) == 0, e, $urandom_range(0, 47) == 0);
        end

        for (int i = 0; i < 10000 && !done_def; i++) @(negedge clk);
        check("default-config block finished", done_def, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Default parameters: 8000-cycle period, 176-cycle latency.
    initial begin
        int first_cs, first_v;
        logic [11:0] v0, v1;
        d_rst_n = 1'b0; d_en = 1'b1;
        first_cs = -1; first_v = -1; v0 = '1; v1 = '1;
        repeat (5) @(negedge clk);
        check("default reset state", {d_cs_n, d_sclk, d_busy, d_valid, d_ovr, d_data0, d_data1},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0});
        d_rst_n = 1'b1;
        for (int i = 1; i <= 8300; i++) begin
            @(negedge clk);
            if (first_cs < 0 && !d_cs_n) first_cs = i;
            if (first_v < 0 && d_valid) begin
                first_v = i; v0 = d_data0; v1 = d_data1;
            end
        end
        check("default first CS_N fall", first_cs, 8000);
        check("default first VALID", first_v, 8175);
        check("default DATA", {v0, v1}, {12'hFFF, 12'h000});
        done_def = 1'b1;
    end

endmodule
`default_nettype wire
